booth_seq_multiplier: RTL and testbench
=======================================

Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier, parametrised in operand width, selectable signed/unsigned mode per operation.
- One Booth iteration per clock, start/done handshake.
- Produces the full 2*WIDTH-bit product.
- Successor to the team's combinational fixed-width Booth multiplier; sits behind the digit-decode front end and feeds display/accumulator logic.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- signed_mode  input  1  1: operands are two's complement; 0: operands are unsigned; sampled with start
- multiplicand  input  WIDTH  operand A, sampled on accept
- multiplier  input  WIDTH  operand B, sampled on accept
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse, product valid
- product  output  2*WIDTH  result, held until next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, iteration counter=0, internal A/S/P registers=0.
- Internal width W1=WIDTH+1. On accept, both operands are extended to W1 bits: sign-extended if signed_mode=1, zero-extended if signed_mode=0. This lets one datapath serve both modes.
- Registers:
  - A = {ext(multiplicand), W1+1 zeros}
  - S = {-ext(multiplicand), W1+1 zeros}
  - P = {W1 zeros, ext(multiplier), 1'b0}
  - All are 2*W1+1 bits; addition is modulo 2^(2*W1+1).
- Accept: on a rising edge with state=IDLE and start=1, the operands and mode are captured. The next state is RUN, busy goes to 1 and the counter is cleared.
- RUN: each edge performs one step, selected by P[1:0]:
  - 01: P=P+A
  - 10: P=P+S
  - 00 or 11: no add
  - Then P is arithmetic-shifted right by 1 (MSB replicated) and the counter is incremented.
- Completion: on the edge performing iteration W1 (counter reaching W1):
  - product <= P_next[2*WIDTH:1], the low 2*WIDTH bits of the true product.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: accept edge E0, iteration edges E1..E(W1). done is high for exactly the one cycle following E(W1), i.e. WIDTH+1 cycles after accept.
- done deasserts on the next edge unconditionally.
- Back-to-back operation: start=1 during the done cycle is accepted (state is IDLE), so the sustained throughput is one result per WIDTH+2 cycles.
- start=1 while busy=1 is ignored: no capture, no queueing, current operation unaffected.
- Operand or signed_mode changes during RUN have no effect.
- product is never updated mid-operation; it keeps the previous result until done.
- Edge operands:
  - The most-negative signed operand (-2^(WIDTH-1)) is correct, because the W1 extension avoids negation overflow in S.
  - Unsigned all-ones inputs are exact.
- Reset mid-operation: immediate abort to reset values; no done is produced.
- Single FSM with two states, IDLE and RUN. The done cycle is IDLE with the done register set; there is no separate DONE state.

Decomposition:
- Package mul_pkg:
  - Booth recode constants for the four P[1:0] cases.
  - State enum {IDLE, RUN}.
  - Helper function for counter width, clog2(WIDTH+2).
- Sub-module booth_step (combinational):
  - Inputs: P, A, S.
  - Output: next P (add/subtract/none plus arithmetic shift).
  - Parametrised by total width 2*W1+1.
  - Instantiated once in the sequential top; also unit-testable on its own.

Test Plan:
All cases use WIDTH=8; results are checked at the done pulse.
1. Signed small mixed: signed_mode=1, A=0xFD (-3), B=0x05 -> product=0xFFF1 (-15); done exactly 9 cycles after accept; busy high 9 cycles.
2. Signed corner: A=0x80, B=0x80 (-128*-128) -> 0x4000. Also A=0x80, B=0x7F -> 0xC080 (-16256).
3. Unsigned full-scale: signed_mode=0, A=0xFF, B=0xFF -> 0xFE01. Same bits with signed_mode=1 -> 0x0001.
4. Zero and identity: A=0x00, B=0xA5 -> 0x0000. A=0x01, B=0xA5, unsigned -> 0x00A5; signed -> 0xFFA5.
5. Handshake: start pulsed again 3 cycles after accept with different operands -> ignored, first result delivered. start held during the done cycle -> second operation accepted, second done 10 cycles after the first.
6. Reset mid-operation: rst_n low 4 cycles after accept -> busy=0, done=0, product=0 immediately (asynchronous). After release, a new operation 7*6 -> 0x002A.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier: recode
// constants for the P[1:0] pair, FSM states and the counter width helper.
package mul_pkg;

    localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The counter must hold WIDTH+1, so size it for WIDTH+2 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: conditional add of A or S into P
// selected by P[1:0], followed by an arithmetic right shift by one.
module booth_step
    import mul_pkg::*;
#(
    parameter int PW = 19
) (
    input  logic [PW-1:0] p_i,
    input  logic [PW-1:0] a_i,
    input  logic [PW-1:0] s_i,
    output logic [PW-1:0] p_next_o
);

    logic [PW-1:0] sum;

    always_comb begin
        sum = p_i;
        unique case (p_i[1:0])
            BOOTH_ADD: sum = p_i + a_i;
            BOOTH_SUB: sum = p_i + s_i;
            default:   sum = p_i;
        endcase
        p_next_o = {sum[PW-1], sum[PW-1:1]};
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, start/done
// handshake, signed or unsigned operands selected per operation.
module booth_seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int W1 = WIDTH + 1;
    localparam int PW = 2 * W1 + 1;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(W1 - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        a_q, a_d;
    logic [PW-1:0]        s_q, s_d;
    logic [PW-1:0]        p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [PW-1:0]        p_step;
    logic [W1-1:0]        mc_ext;
    logic [W1-1:0]        mp_ext;
    logic [W1-1:0]        mc_neg;

    // One extra bit lets a single datapath cover both modes and keeps
    // the negation of the most-negative signed operand representable.
    always_comb begin
        mc_ext = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
        mp_ext = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};
        mc_neg = W1'(0) - mc_ext;
    end

    booth_step #(
        .PW(PW)
    ) u_step (
        .p_i      (p_q),
        .a_i      (a_q),
        .s_i      (s_q),
        .p_next_o (p_step)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        s_d       = s_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    a_d     = {mc_ext, {(W1 + 1){1'b0}}};
                    s_d     = {mc_neg, {(W1 + 1){1'b0}}};
                    p_d     = {{W1{1'b0}}, mp_ext, 1'b0};
                end
            end
            RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = p_step[2*WIDTH:1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            s_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            s_q       <= s_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier (WIDTH=8): stimulus pushes the
// expected product and accept cycle, a negedge monitor checks each done pulse.
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          acc;
        string       name;
    } exp_t;

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        string       name;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(product), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_product"}, 32'(product), 32'(mon_e.prod));
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'd9);
                $display("op %s: product=0x%04h expected=0x%04h done_cycle=%0d", mon_e.name,
                         product, mon_e.prod, cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input string name, input bit push);
        int guard = 0;
        exp_t e;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check({name, "_wait_idle"}, 32'(busy), 32'd0);
        start        = 1'b1;
        signed_mode  = sm;
        multiplicand = a;
        multiplier   = b;
        if (push) begin
            e.prod = prod;
            e.acc  = cyc + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start        = 1'b0;
        signed_mode  = ~sm;
        multiplicand = ~a;
        multiplier   = ~b;
    endtask

    task automatic wait_done(input string name, output int when);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!done && guard < 50);
        if (!done) check({name, "_done_timeout"}, 32'(done), 32'd1);
        when = cyc;
    endtask

    vec_t vecs[11];

    initial begin
        int n_busy;
        int t1;
        int t2;
        int guard;

        vecs[0]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, "s_m3x5"};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_m128xm128"};
        vecs[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080, "s_m128x127"};
        vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff"};
        vecs[4]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1xm1"};
        vecs[5]  = '{1'b1, 8'h00, 8'hA5, 16'h0000, "s_0xa5"};
        vecs[6]  = '{1'b0, 8'h01, 8'hA5, 16'h00A5, "u_1xa5"};
        vecs[7]  = '{1'b1, 8'h01, 8'hA5, 16'hFFA5, "s_1xa5"};
        vecs[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000, "u_80x80"};
        vecs[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_127x127"};
        vecs[10] = '{1'b0, 8'h7F, 8'h02, 16'h00FE, "u_7fx02"};

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First vector also checks the busy window length.
        issue(vecs[0].sm, vecs[0].a, vecs[0].b, vecs[0].prod, vecs[0].name, 1'b1);
        n_busy = 0;
        while (busy && n_busy < 30) begin
            n_busy++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n_busy), 32'd9);

        for (int i = 1; i < 11; i++) begin
            issue(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].name, 1'b1);
        end

        // A start during RUN must be ignored.
        issue(1'b0, 8'h03, 8'h04, 16'h000C, "u_3x4", 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        signed_mode = 1'b0;
        multiplicand = 8'h11;
        multiplier = 8'h22;
        @(negedge clk);
        start = 1'b0;

        // Start held during the done cycle is accepted immediately.
        wait_done("u_3x4", t1);
        issue(1'b1, 8'hFE, 8'h03, 16'hFFFA, "s_m2x3_b2b", 1'b1);
        wait_done("s_m2x3_b2b", t2);
        check("b2b_spacing", 32'(t2 - t1), 32'd10);
        @(negedge clk);
        issue(1'b0, 8'h10, 8'h10, 16'h0100, "u_10x10", 1'b1);
        wait_done("u_10x10", t1);
        @(negedge clk);

        // Abort by reset: the operation below must never complete.
        issue(1'b0, 8'h55, 8'h02, 16'h00AA, "aborted", 1'b0);
        repeat (3) @(negedge clk);
        check("product_held", 32'(product), 32'h0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 8'h07, 8'h06, 16'h002A, "u_7x6", 1'b1);

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (12) @(negedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
